// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multicycle sequencer for the unsigned MULTU/DIVU datapath and the HI/LO
// register pair. A multiply runs a shift-add loop, a divide runs a restoring
// divider. Each retires one bit per cycle, and the result is committed to HI/LO
// when the iteration counter expires.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - a multiply commits as soon as the multiplier bits that
//                         have not been consumed are all zero. The accumulator
//                         is shifted by the remaining count in that same step.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start_multu  in   request hi:lo = op_a * op_b (wins if both starts are high)
//   start_divu   in   request lo = op_a / op_b, hi = op_a % op_b
//   op_a, op_b   in   rs / rt operands, WIDTH bits
//   mf_req       in   MFHI/MFLO present in the execute stage
//   flush        in   abort an in-flight operation; also blocks a start in IDLE/DONE
//   hi, lo       out  HI/LO registers
//   busy         out  an operation is iterating (MUL or DIV)
//   done         out  one-cycle pulse after a commit
//   stall        out  busy & (mf_req | start_multu | start_divu)
//   div0         out  sticky divide-by-zero flag, cleared by the next accepted start
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation; starts are accepted here
// MUL   | shift-add multiply iterating
// DIV   | restoring divide iterating (exits after one cycle for op_b == 0)
// DONE  | HI/LO were just written; done=1; starts are accepted here
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_multu,
    input  logic             start_divu,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div0
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // r_acc: for a multiply, the upper half accumulates the product and the
    // lower half holds the multiplier, which shifts out from the bottom. For a
    // divide, the lower half holds the dividend, which shifts out from the top
    // while quotient bits shift in from the bottom.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;     // partial remainder (always < divisor)
    logic [WIDTH-1:0]   r_opnd;    // multiplicand or divisor
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div0;

    logic               w_idle_like;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH-1:0] w_mul_result;
    logic               w_mul_done;

    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic               w_div_zero;
    logic               w_div_done;

`ifdef MULDIV_EARLY_OUT_EN
    logic               w_rest_zero;
    logic [CNT_W-1:0]   w_shamt;
`endif

    // ------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------
    always_comb begin
        w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
        w_accept    = w_idle_like && !flush && (start_multu || start_divu);
        w_last      = (r_cnt == CNT_W'(1));

        // Multiply step: conditionally add the multiplicand to the upper half,
        // then shift the whole accumulator right. The carry is shifted in at the top.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
        // After this step, bits [r_cnt-1:1] of the low half are multiplier
        // bits that have not been consumed. If they are all zero, finishing
        // the loop is only a pure shift.
        w_rest_zero = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((i < int'(r_cnt)) && r_acc[i]) begin
                w_rest_zero = 1'b0;
            end
        end
        w_shamt      = r_cnt - CNT_W'(1);
        w_mul_result = w_rest_zero ? (w_mul_step >> w_shamt) : w_mul_step;
        w_mul_done   = w_last || w_rest_zero;
`else
        w_mul_result = w_mul_step;
        w_mul_done   = w_last;
`endif

        // Restoring divide step. w_div_sh < 2*divisor. Bit WIDTH of the
        // (WIDTH+1)-bit difference is therefore set exactly when the trial
        // subtraction went negative.
        w_div_sh   = {r_rem, r_acc[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_opnd};
        w_div_ge   = ~w_div_diff[WIDTH];
        w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_div_quo  = {r_acc[WIDTH-2:0], w_div_ge};
        w_div_zero = (r_opnd == '0);
        w_div_done = w_last || w_div_zero;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = start_multu ? S_MUL : S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_mul_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_div_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_div0 <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= CNT_W'(WIDTH);
            r_rem  <= '0;
            r_div0 <= 1'b0;
            if (start_multu) begin
                r_acc  <= {{WIDTH{1'b0}}, op_b};
                r_opnd <= op_a;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, op_a};
                r_opnd <= op_b;
            end
        end else if ((r_state == S_MUL || r_state == S_DIV) && flush) begin
            // Abort: HI/LO and div0 keep their previous values.
            r_cnt <= '0;
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_result;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_mul_done) begin
                r_hi  <= w_mul_result[2*WIDTH-1:WIDTH];
                r_lo  <= w_mul_result[WIDTH-1:0];
                r_cnt <= '0;
            end
        end else if (r_state == S_DIV) begin
            if (w_div_zero) begin
                r_hi   <= r_acc[WIDTH-1:0];
                r_lo   <= '1;
                r_div0 <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_rem            <= w_div_rem;
                r_acc[WIDTH-1:0] <= w_div_quo;
                r_cnt            <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_hi <= w_div_rem;
                    r_lo <= w_div_quo;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign div0  = r_div0;
    assign busy  = (r_state == S_MUL) || (r_state == S_DIV);
    assign done  = (r_state == S_DONE);
    assign stall = busy && (mf_req || start_multu || start_divu);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_multu;
    logic          start_divu;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          mf_req;
    logic          flush;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          stall;
    logic          div0;

    int checks   = 0;
    int failures = 0;

    // Expected architectural HI/LO/div0 after the most recent commit
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;
    logic          m_div0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_multu (start_multu),
        .start_divu  (start_divu),
        .op_a        (op_a),
        .op_b        (op_b),
        .mf_req      (mf_req),
        .flush       (flush),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .stall       (stall),
        .div0        (div0)
    );

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Cycles from the accept edge to the commit edge
    function automatic int exp_lat(input bit is_div, input logic [31:0] b);
        int l;
        l = 32;
        if (is_div) l = (b == 0) ? 1 : 32;
`ifdef MULDIV_EARLY_OUT_EN
        else begin
            l = 1;
            for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
        end
`endif
        return l;
    endfunction

    // Reference result from plain unsigned arithmetic
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output bit e_dz);
        logic [63:0] p;
        if (!is_div) begin
            p    = 64'(a) * 64'(b);
            e_hi = p[63:32];
            e_lo = p[31:0];
            e_dz = 1'b0;
        end else if (b == 0) begin
            e_hi = a;
            e_lo = 32'hFFFF_FFFF;
            e_dz = 1'b1;
        end else begin
            e_hi = a % b;
            e_lo = a / b;
            e_dz = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi,
                          input logic [31:0] e_lo, input bit e_dz);
        int n;
        op_a        = a;
        op_b        = b;
        start_multu = !is_div;
        start_divu  = is_div;
        @(posedge clk); #1;
        start_multu = 1'b0;
        start_divu  = 1'b0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'(1));
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat(is_div, b)));
        check({tag, " hi"}, 64'(hi), 64'(e_hi));
        check({tag, " lo"}, 64'(lo), 64'(e_lo));
        check({tag, " div0"}, 64'(div0), 64'(e_dz));
        m_hi   = e_hi;
        m_lo   = e_lo;
        m_div0 = e_dz;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        bit          e_dz;
        bit          rdiv;
        bit          seen_done;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};
        vecs[4] = '{1'b0, 32'h0000_1234, 32'd1,         32'd0,         32'h0000_1234, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b1, 32'd7,         32'd100,       32'd7,         32'd0,         1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0};

        rst_n       = 1'b0;
        start_multu = 1'b0;
        start_divu  = 1'b0;
        op_a        = '0;
        op_b        = '0;
        mf_req      = 1'b0;
        flush       = 1'b0;
        m_hi        = '0;
        m_lo        = '0;
        m_div0      = 1'b0;

        // Reset state
        #12;
        check("reset hi",    64'(hi),    64'(0));
        check("reset lo",    64'(lo),    64'(0));
        check("reset busy",  64'(busy),  64'(0));
        check("reset done",  64'(done),  64'(0));
        check("reset div0",  64'(div0),  64'(0));
        mf_req      = 1'b1;
        start_multu = 1'b1;
        #1;
        check("reset stall", 64'(stall), 64'(0));
        mf_req      = 1'b0;
        start_multu = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
            @(posedge clk); #1;
            check($sformatf("vec%0d done_pulse_end", i), 64'(done), 64'(0));
            check($sformatf("vec%0d idle_after", i), 64'(busy), 64'(0));
        end

        // MULTU with mf_req from cycle 3 and a DIVU request held while busy
        model(1'b0, 32'h1234_5678, 32'h8000_0001, e_hi, e_lo, e_dz);
        op_a        = 32'h1234_5678;
        op_b        = 32'h8000_0001;
        start_multu = 1'b1;
        @(posedge clk); #1;
        start_multu = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            if (c >= 3) mf_req = 1'b1;
            if (c >= 4 && c < 8) begin
                start_divu = 1'b1;
                op_b       = 32'd0;
            end else begin
                start_divu = 1'b0;
            end
            #1;
            check($sformatf("stall_seq stall c%0d", c), 64'(stall), 64'(c >= 3 && c < 32));
            check($sformatf("stall_seq done c%0d", c), 64'(done), 64'(c == 32));
        end
        check("stall_seq hi", 64'(hi), 64'(e_hi));
        check("stall_seq lo", 64'(lo), 64'(e_lo));
        check("stall_seq div0", 64'(div0), 64'(0));
        mf_req = 1'b0;
        m_hi   = e_hi;
        m_lo   = e_lo;
        m_div0 = e_dz;
        @(posedge clk); #1;

        // DIVU flushed at cycle 10
        op_a       = 32'd1000;
        op_b       = 32'd3;
        start_divu = 1'b1;
        @(posedge clk); #1;
        start_divu = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        check("flush busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        check("flush done", 64'(done), 64'(0));
        check("flush hi", 64'(hi), 64'(m_hi));
        check("flush lo", 64'(lo), 64'(m_lo));
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("flush no_restart", 64'(seen_done), 64'(0));

        // flush on the would-be commit edge wins
        op_a        = 32'hCAFE_F00D;
        op_b        = 32'h8000_0007;
        start_multu = 1'b1;
        @(posedge clk); #1;
        start_multu = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
        end
        check("flush_commit busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_commit done", 64'(done), 64'(0));
        check("flush_commit busy", 64'(busy), 64'(0));
        check("flush_commit hi", 64'(hi), 64'(m_hi));
        check("flush_commit lo", 64'(lo), 64'(m_lo));

        // flush in IDLE suppresses a start
        op_a        = 32'd9;
        op_b        = 32'd9;
        start_multu = 1'b1;
        flush       = 1'b1;
        @(posedge clk); #1;
        start_multu = 1'b0;
        flush       = 1'b0;
        check("flush_idle busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("flush_idle done", 64'(done), 64'(0));
        check("flush_idle lo", 64'(lo), 64'(m_lo));

        // Asynchronous reset in the middle of a multiply
        op_a        = 32'hFFFF_FFFF;
        op_b        = 32'h8000_0003;
        start_multu = 1'b1;
        @(posedge clk); #1;
        start_multu = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        check("areset busy_before", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset hi",   64'(hi),   64'(0));
        check("areset lo",   64'(lo),   64'(0));
        check("areset busy", 64'(busy), 64'(0));
        check("areset div0", 64'(div0), 64'(0));
        rst_n  = 1'b1;
        m_hi   = '0;
        m_lo   = '0;
        m_div0 = 1'b0;
        @(posedge clk); #1;

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra   = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(0, 255));
                3:       rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            model(rdiv, ra, rb, e_hi, e_lo, e_dz);
            run_op($sformatf("rand%0d", i), rdiv, ra, rb, e_hi, e_lo, e_dz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
